// File: rtl/options_field_collector_if.sv
// Byte-in / array-out handshake bundle for the options field collector.
// The master modport is the surrounding producer/consumer view; the slave modport is the collector.
interface options_field_collector_if #(
  parameter int NUM_FIELDS = 15
);
  logic [8:0]              byteIn_sig;
  logic                    byteIn_sync;
  logic                    byteIn_notify;
  logic [8*NUM_FIELDS-1:0] fieldsOut_sig;
  logic [3:0]              fieldsOut_len;
  logic                    fieldsOut_trunc;
  logic                    fieldsOut_sync;
  logic                    fieldsOut_notify;

  modport master (
    output byteIn_sig, byteIn_sync, fieldsOut_sync,
    input  byteIn_notify, fieldsOut_sig, fieldsOut_len, fieldsOut_trunc, fieldsOut_notify
  );

  modport slave (
    input  byteIn_sig, byteIn_sync, fieldsOut_sync,
    output byteIn_notify, fieldsOut_sig, fieldsOut_len, fieldsOut_trunc, fieldsOut_notify
  );
endinterface

// File: rtl/options_field_collector.sv
// Packs a header's option bytes into a fixed array for the options parser.
// Over-long frames are truncated to NUM_FIELDS entries and their remaining bytes are drained.
module options_field_collector #(
  parameter int         NUM_FIELDS = 15,
  parameter logic [7:0] PAD_VALUE  = 8'h00
) (
  input logic                   clk,
  input logic                   rst,
  options_field_collector_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DISCARD = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_FIELDS - 1);
  localparam logic [3:0] FULL_LEN = 4'(NUM_FIELDS);

  state_t                      state_r;
  logic [3:0]                  counter_r;
  logic [NUM_FIELDS-1:0][7:0]  fields_r;
  logic [3:0]                  len_r;
  logic                        trunc_r;
  logic                        byte_notify_r;
  logic                        fields_notify_r;

  logic                        byte_xfer_s;
  logic                        fields_xfer_s;
  logic                        last_s;
  logic [7:0]                  data_s;

  assign byte_xfer_s   = byte_notify_r & bus.byteIn_sync;
  assign fields_xfer_s = fields_notify_r & bus.fieldsOut_sync;
  assign last_s        = bus.byteIn_sig[8];
  assign data_s        = bus.byteIn_sig[7:0];

  assign bus.byteIn_notify    = byte_notify_r;
  assign bus.fieldsOut_notify = fields_notify_r;
  assign bus.fieldsOut_sig    = fields_r;
  assign bus.fieldsOut_len    = len_r;
  assign bus.fieldsOut_trunc  = trunc_r;

  // Frame FSM; notifies are registered alongside the state so they never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= COLLECT;
      counter_r       <= 4'd0;
      fields_r        <= {NUM_FIELDS{PAD_VALUE}};
      len_r           <= 4'd0;
      trunc_r         <= 1'b0;
      byte_notify_r   <= 1'b0;
      fields_notify_r <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          byte_notify_r   <= 1'b1;
          fields_notify_r <= 1'b0;
          if (byte_xfer_s) begin
            fields_r[counter_r] <= data_s;
            // Counter saturates at the last index; it is cleared when the array is taken.
            if (counter_r != LAST_IDX) begin
              counter_r <= counter_r + 4'd1;
            end
            if (last_s) begin
              len_r           <= counter_r + 4'd1;
              trunc_r         <= 1'b0;
              state_r         <= EMIT;
              byte_notify_r   <= 1'b0;
              fields_notify_r <= 1'b1;
            end else if (counter_r == LAST_IDX) begin
              len_r   <= FULL_LEN;
              trunc_r <= 1'b1;
              state_r <= DISCARD;
            end
          end
        end
        DISCARD: begin
          byte_notify_r   <= 1'b1;
          fields_notify_r <= 1'b0;
          if (byte_xfer_s && last_s) begin
            state_r         <= EMIT;
            byte_notify_r   <= 1'b0;
            fields_notify_r <= 1'b1;
          end
        end
        EMIT: begin
          byte_notify_r   <= 1'b0;
          fields_notify_r <= 1'b1;
          if (fields_xfer_s) begin
            fields_r        <= {NUM_FIELDS{PAD_VALUE}};
            counter_r       <= 4'd0;
            len_r           <= 4'd0;
            trunc_r         <= 1'b0;
            state_r         <= COLLECT;
            byte_notify_r   <= 1'b1;
            fields_notify_r <= 1'b0;
          end
        end
        default: begin
          state_r         <= COLLECT;
          counter_r       <= 4'd0;
          fields_r        <= {NUM_FIELDS{PAD_VALUE}};
          len_r           <= 4'd0;
          trunc_r         <= 1'b0;
          byte_notify_r   <= 1'b0;
          fields_notify_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_options_field_collector.sv
// Bench for options_field_collector: directed frames with literal expectations, then random traffic
// checked every cycle against a frame-level model (queue of accepted bytes -> expected array).
module tb_options_field_collector;

  logic clk = 1'b0;
  logic rst;

  options_field_collector_if #(.NUM_FIELDS(15)) bus ();

  options_field_collector #(.NUM_FIELDS(15), .PAD_VALUE(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame-level model state
  logic [7:0]   frame_q[$];
  logic [119:0] exp_sig   = '0;
  logic [3:0]   exp_len   = 4'd0;
  logic         exp_trunc = 1'b0;
  bit           pend      = 1'b0;
  bit           in_ok     = 1'b0;

  task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes accepted form a frame; on last, the expected array is the first 15 bytes padded.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q.delete();
      pend  = 1'b0;
      in_ok = 1'b0;
    end else if (pend) begin
      if (bus.fieldsOut_sync) begin
        pend  = 1'b0;
        in_ok = 1'b1;
      end
    end else if (!in_ok) begin
      in_ok = 1'b1;
    end else if (bus.byteIn_sync) begin : accept
      int n;
      frame_q.push_back(bus.byteIn_sig[7:0]);
      if (bus.byteIn_sig[8]) begin
        n         = frame_q.size();
        exp_len   = 4'((n > 15) ? 15 : n);
        exp_trunc = (n > 15);
        exp_sig   = '0;
        for (int i = 0; i < int'(exp_len); i++) exp_sig[8*i +: 8] = frame_q[i];
        frame_q.delete();
        pend  = 1'b1;
        in_ok = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_notify",  120'(bus.byteIn_notify),    120'd0);
      check("rst_out_notify", 120'(bus.fieldsOut_notify), 120'd0);
    end else begin
      check("in_notify",  120'(bus.byteIn_notify),    120'(in_ok));
      check("out_notify", 120'(bus.fieldsOut_notify), 120'(pend));
      if (pend) begin
        check("out_sig",   bus.fieldsOut_sig,          exp_sig);
        check("out_len",   120'(bus.fieldsOut_len),    120'(exp_len));
        check("out_trunc", 120'(bus.fieldsOut_trunc),  120'(exp_trunc));
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit last);
    int t;
    t = 0;
    bus.byteIn_sig  = {last, d};
    bus.byteIn_sync = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.byteIn_notify && t < 100);
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h never accepted", d);
    end
    @(posedge clk);
    #1;
    bus.byteIn_sync = 1'b0;
  endtask

  // Checks the array in the cycle right after the last byte, then takes it.
  task automatic expect_array(input string name, input logic [119:0] sig,
                              input logic [3:0] len, input logic trunc);
    @(negedge clk);
    check({name, "_notify"}, 120'(bus.fieldsOut_notify), 120'd1);
    check({name, "_sig"},    bus.fieldsOut_sig,          sig);
    check({name, "_len"},    120'(bus.fieldsOut_len),    120'(len));
    check({name, "_trunc"},  120'(bus.fieldsOut_trunc),  120'(trunc));
    bus.fieldsOut_sync = 1'b1;
    @(posedge clk);
    #1;
    bus.fieldsOut_sync = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    bus.byteIn_sig     = 9'd0;
    bus.byteIn_sync    = 1'b0;
    bus.fieldsOut_sync = 1'b0;
    @(negedge clk);
    check("reset_sig",   bus.fieldsOut_sig,         120'd0);
    check("reset_len",   120'(bus.fieldsOut_len),   120'd0);
    check("reset_trunc", 120'(bus.fieldsOut_trunc), 120'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Short frame
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
    expect_array("t_short", 120'h000000000000000000000000030201, 4'd3, 1'b0);

    // Exactly full frame
    for (int i = 0; i < 15; i++) send(8'(8'h10 + i), (i == 14));
    expect_array("t_full", 120'h1E1D1C1B1A19181716151413121110, 4'd15, 1'b0);

    // Over-long frame truncated
    for (int i = 0; i < 20; i++) send(8'(8'h20 + i), (i == 19));
    expect_array("t_trunc", 120'h2E2D2C2B2A29282726252423222120, 4'd15, 1'b1);

    // Consumer stall while producer keeps pushing
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b1);
    bus.byteIn_sig  = 9'h1EE;
    bus.byteIn_sync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_notify", 120'(bus.byteIn_notify), 120'd0);
      check("stall_sig", bus.fieldsOut_sig, 120'h000000000000000000000000776655);
    end
    bus.byteIn_sync    = 1'b0;
    bus.fieldsOut_sync = 1'b1;
    @(posedge clk);
    #1 bus.fieldsOut_sync = 1'b0;

    // Asynchronous reset mid-frame
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_in_notify",  120'(bus.byteIn_notify),    120'd0);
    check("async_rst_out_notify", 120'(bus.fieldsOut_notify), 120'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    expect_array("t_after_rst", 120'h0000000000000000000000000000BBAA, 4'd2, 1'b0);

    // Back-to-back single-byte frames with byteIn_sync held high through EMIT
    send(8'h7F, 1'b1);
    bus.byteIn_sig  = 9'h13C;
    bus.byteIn_sync = 1'b1;
    expect_array("t_single_a", 120'h00000000000000000000000000007F, 4'd1, 1'b0);
    send(8'h3C, 1'b1);
    expect_array("t_single_b", 120'h00000000000000000000000000003C, 4'd1, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      bus.byteIn_sync    = ($urandom_range(0, 3) != 0);
      bus.byteIn_sig     = {($urandom_range(0, 11) == 0), 8'($urandom)};
      bus.fieldsOut_sync = ($urandom_range(0, 2) == 0);
    end
    bus.byteIn_sync    = 1'b0;
    bus.fieldsOut_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/options_field_collector.md
Name: options_field_collector

Overview:
- Sits directly upstream of the options parser and feeds its 15-entry byte-array input (fieldsIn).
- Accepts the options area of a header one byte per transfer.
- Packs the bytes into a fixed 15-entry array, padding unused entries, and offers the array on a sync/notify output channel.
- Frames longer than 15 bytes are truncated, the excess is drained, and the truncation is flagged.

Parameters:
- NUM_FIELDS, 15: array entries. The fixed parser interface requires exactly 15; the counter is sized for this value.
- PAD_VALUE, 8'h00: value written to entries not filled by the current frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- byteIn_sig  in  9  bit 8 = last-byte-of-frame flag, bits 7:0 = option byte.
- byteIn_sync  in  1  producer has a valid byte.
- byteIn_notify  out  1  block can accept a byte this cycle.
- fieldsOut_sig  out  120  entry i at bits [8i+7:8i]; bus-compatible with the parser's fieldsIn_sig.
- fieldsOut_len  out  4  number of valid entries, 1..15.
- fieldsOut_trunc  out  1  frame exceeded NUM_FIELDS bytes.
- fieldsOut_sync  in  1  consumer takes the array.
- fieldsOut_notify  out  1  array valid and offered.

Behaviour:
- Transfer rule: a transfer occurs on a channel in any cycle where notify and sync are both high at the rising clk edge. sig is ignored at all other times.
- Registers: state ∈ {COLLECT, DISCARD, EMIT}, 4-bit counter, 15x8 fields array, len, trunc.
- Reset (rst=1, asynchronous): state=COLLECT, counter=0, all fields=PAD_VALUE, len=0, trunc=0, both notify outputs held at 0. Reset mid-frame discards the partial frame. byteIn_notify rises on the first clk edge after rst falls.
- Notify decode: byteIn_notify=1 in COLLECT and DISCARD; fieldsOut_notify=1 only in EMIT. The two notifies are never high together.
- COLLECT, on a byte transfer:
  - fields[counter] = data; counter += 1.
  - If last=1: len=counter+1, trunc=0, go to EMIT.
  - Else if counter==NUM_FIELDS-1: len=15, trunc=1, go to DISCARD.
  - Else: stay in COLLECT.
- DISCARD: accept and drop bytes with fields unchanged. On a transfer with last=1, go to EMIT.
- Special case: a 15th byte arriving with last=1 goes straight to EMIT with trunc=0.
- EMIT:
  - fieldsOut_sig, fieldsOut_len and fieldsOut_trunc are stable for as long as notify is high.
  - On a fieldsOut transfer: fields=PAD_VALUE, counter=0, go to COLLECT.
  - byteIn is stalled (byteIn_notify=0) for the whole of EMIT.
- Latency:
  - A last byte accepted at edge t gives fieldsOut_notify=1 in the cycle after t.
  - The earliest next byte is accepted one cycle after the array is taken.
  - Maximum throughput is one byte per cycle while collecting.
- Counter: never wraps; its maximum value is NUM_FIELDS-1. Entries beyond len are always PAD_VALUE.
- Simultaneous events: input and output transfers cannot coincide because the notifies are exclusive. sync asserted while its notify is low has no effect.

Test Plan:
- Reset, then frame 01,02,03 with last on 03, fieldsOut_sync=1 -> fieldsOut_notify at cycle after 03; entries0..2=01,02,03, entries3..14=00, len=3, trunc=0.
- Exactly 15 bytes 10..1E, last on 1E -> all entries filled, len=15, trunc=0, no DISCARD cycles.
- 20 bytes 20..33, last on 33 -> entries=20..2E, len=15, trunc=1. Bytes 2F..33 are accepted but have no effect. notify rises the cycle after 33.
- Hold fieldsOut_sync=0 for 10 cycles in EMIT while driving byteIn_sync=1 -> byteIn_notify=0 throughout; output bits stable; after the transfer the next frame starts with entries=00.
- Assert rst asynchronously after 4 bytes of a frame -> notifies drop immediately. A following 2-byte frame AA,BB gives len=2, entries2..14=00, with no old data visible.
- Single-byte frame 7F with last=1, back-to-back with another -> len=1. Second array is offered correctly with no byte lost; byteIn_sync held high is honoured only when byteIn_notify=1.
